core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl_if.sv | 13 +
 rtl/core_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// Host program-load stream: valid/ready handshake carrying instruction words.
// The host side is the master; core_run_ctrl is the slave.
interface core_run_ctrl_if;
   localparam int unsigned DATA_W = 32;

   logic              host_valid;
   logic              host_ready;
   logic [DATA_W-1:0] host_data;
   logic              host_last;

   modport master (output host_valid, output host_data, output host_last, input host_ready);
   modport slave  (input host_valid, input host_data, input host_last, output host_ready);
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for riscv_core: loads a program into imem, then holds the core in reset,
// runs it for a cycle budget and reports completion. Define RUN_CTRL_HALT_EN for a core_halt exit.
module core_run_ctrl #(
   parameter int unsigned IMEM_DEPTH = 64,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned CYCLE_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   core_run_ctrl_if.slave     host,
   input  logic               start,
   input  logic [CYCLE_W-1:0] cycle_budget,
`ifdef RUN_CTRL_HALT_EN
   input  logic               core_halt,
`endif
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               core_rst,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W:0]    loaded_words,
   output logic [CYCLE_W-1:0] cycles,
   output logic               err
);

   localparam int unsigned       CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

   state_t             state_q, state_nxt;
   logic [ADDR_W-1:0]  ptr_q, ptr_nxt;
   logic [CYCLE_W-1:0] budget_q, budget_nxt;
   logic [CYCLE_W-1:0] cycles_q, cycles_nxt;
   logic               hold_q, hold_nxt;
   logic [CNT_W-1:0]   loaded_q, loaded_nxt;
   logic               err_q, err_nxt;

   logic               ready_c;
   logic               accept_c;
   logic [ADDR_W-1:0]  wr_addr_c;
   logic [CYCLE_W-1:0] cycles_inc_c;
   logic               halt_c;

`ifdef RUN_CTRL_HALT_EN
   assign halt_c = core_halt;
`else
   assign halt_c = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         budget_q <= '0;
         cycles_q <= '0;
         hold_q   <= 1'b0;
         loaded_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         ptr_q    <= ptr_nxt;
         budget_q <= budget_nxt;
         cycles_q <= cycles_nxt;
         hold_q   <= hold_nxt;
         loaded_q <= loaded_nxt;
         err_q    <= err_nxt;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_nxt    = state_q;
      ptr_nxt      = ptr_q;
      budget_nxt   = budget_q;
      cycles_nxt   = cycles_q;
      hold_nxt     = hold_q;
      loaded_nxt   = loaded_q;
      err_nxt      = err_q;
      ready_c      = (state_q == S_IDLE) || (state_q == S_LOAD);
      accept_c     = ready_c && host.host_valid;
      wr_addr_c    = (state_q == S_IDLE) ? '0 : ptr_q;
      cycles_inc_c = (cycles_q == '1) ? cycles_q : cycles_q + CYCLE_W'(1);

      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept_c) begin
               if (state_q == S_IDLE) err_nxt = 1'b0;
               ptr_nxt = wr_addr_c + ADDR_W'(1);
               if (host.host_last) begin
                  loaded_nxt = {1'b0, wr_addr_c} + CNT_W'(1);
                  state_nxt  = S_IDLE;
               end else if (wr_addr_c == LAST_ADDR) begin
                  err_nxt    = 1'b1;
                  loaded_nxt = '0;
                  state_nxt  = S_IDLE;
               end else begin
                  state_nxt  = S_LOAD;
               end
            end else if ((state_q == S_IDLE) && start && (loaded_q != '0)) begin
               // A word in the same cycle took the accept branch above, so load wins
               budget_nxt = cycle_budget;
               cycles_nxt = '0;
               hold_nxt   = 1'b0;
               state_nxt  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_q) begin
               hold_nxt  = 1'b0;
               state_nxt = (budget_q == '0) ? S_DONE : S_RUN;
            end else begin
               hold_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            if (halt_c) begin
               state_nxt = S_DONE;
            end else begin
               cycles_nxt = cycles_inc_c;
               if (cycles_inc_c == budget_q) state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign host.host_ready = ready_c;
   assign imem_we         = accept_c;
   assign imem_addr       = wr_addr_c;
   assign imem_wdata      = host.host_data;
   assign core_rst        = (state_q != S_RUN);
   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign loaded_words    = loaded_q;
   assign cycles          = cycles_q;
   assign err             = err_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: per-cycle vector table plus load/run/reset/overflow sequences.
module tb_core_run_ctrl;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] cycle_budget;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic [6:0]  loaded_words;
   logic [15:0] cycles;
   logic        err;
`ifdef RUN_CTRL_HALT_EN
   logic        core_halt;
`endif

   core_run_ctrl_if bus ();

   core_run_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host         (bus),
      .start        (start),
      .cycle_budget (cycle_budget),
`ifdef RUN_CTRL_HALT_EN
      .core_halt    (core_halt),
`endif
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .loaded_words (loaded_words),
      .cycles       (cycles),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        hv;
      logic [31:0] hd;
      logic        hl;
      logic        st;
      logic [15:0] bud;
      logic        e_ready;
      logic        e_we;
      logic [5:0]  e_addr;
      logic        e_busy;
      logic        e_rst;
      logic        e_done;
      logic        e_err;
      logic [6:0]  e_lw;
      logic [15:0] e_cyc;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.host_valid = 1'b0;
      bus.host_data  = 32'h0;
      bus.host_last  = 1'b0;
      start          = 1'b0;
      cycle_budget   = 16'd0;
`ifdef RUN_CTRL_HALT_EN
      core_halt      = 1'b0;
`endif
   endtask

   // Drive one word for a cycle and check the same-cycle imem write
   task automatic push_word(input logic [31:0] data, input logic last, input logic [5:0] exp_addr);
      @(negedge clk);
      bus.host_valid = 1'b1;
      bus.host_data  = data;
      bus.host_last  = last;
      #1;
      check("imem_write", {25'd0, imem_we, imem_addr, imem_wdata}, {25'd0, 1'b1, exp_addr, data});
   endtask

   task automatic load(input int n, input logic with_last, input logic [31:0] base);
      for (int i = 0; i < n; i++)
         push_word(base + 32'(i), with_last && (i == n - 1), 6'(i));
      @(negedge clk);
      clear_inputs();
      #1;
   endtask

   task automatic run_measure(input logic [15:0] bud, output int n_hold, output int n_run,
                              output int n_done, output bit timed_out);
      n_hold = 0; n_run = 0; n_done = 0; timed_out = 1'b1;
      @(negedge clk);
      start = 1'b1;
      cycle_budget = bud;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         if (done) n_done++;
         else if (core_rst) n_hold++;
         else n_run++;
         @(negedge clk);
      end
   endtask

   // Wait (bounded) until RUN has counted the given number of cycles
   task automatic wait_run_cycles(input logic [15:0] target, output bit found);
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (!core_rst && cycles == target) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  h, r, d;
      bit  to, found, seen;
      logic [63:0] act, exp;

      // {hv, hd, hl, st, bud | ready, we, addr, busy, core_rst, done, err, lw, cycles}
      vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0};
      vecs[1]  = '{1'b1, 32'hA000_0000, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0};
      vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0};
      vecs[3]  = '{1'b1, 32'hA000_0001, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0};
      vecs[4]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0};
      vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 16'd0};
      vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd3, 16'd0};
      vecs[7]  = '{1'b1, 32'hA000_0003, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd3, 16'd0};
      vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 16'd0};
      vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 16'd1};
      vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 16'd2};
      vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd3, 16'd3};
      vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 16'd3};

      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state",
            {38'd0, bus.host_ready, imem_we, busy, core_rst, done, err, loaded_words, cycles},
            {38'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0});
      @(negedge clk);
      rst_n = 1'b1;

      // Per-cycle table: 3-word load, start ignored in LOAD, budget-3 run
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.host_valid = vecs[i].hv;
         bus.host_data  = vecs[i].hd;
         bus.host_last  = vecs[i].hl;
         start          = vecs[i].st;
         cycle_budget   = vecs[i].bud;
         #1;
         act = {bus.host_ready, imem_we, (imem_we ? imem_addr : 6'd0), (imem_we ? imem_wdata : 32'd0),
                busy, core_rst, done, err, loaded_words, cycles[11:0]};
         exp = {vecs[i].e_ready, vecs[i].e_we, vecs[i].e_addr, (vecs[i].e_we ? vecs[i].hd : 32'd0),
                vecs[i].e_busy, vecs[i].e_rst, vecs[i].e_done, vecs[i].e_err, vecs[i].e_lw,
                vecs[i].e_cyc[11:0]};
         n_vec++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d: ready=%b we=%b addr=%0d wdata=%h busy=%b core_rst=%b done=%b err=%b lw=%0d cycles=%0d, expected ready=%b we=%b addr=%0d busy=%b core_rst=%b done=%b err=%b lw=%0d cycles=%0d",
                     i, bus.host_ready, imem_we, imem_addr, imem_wdata, busy, core_rst, done, err,
                     loaded_words, cycles, vecs[i].e_ready, vecs[i].e_we, vecs[i].e_addr,
                     vecs[i].e_busy, vecs[i].e_rst, vecs[i].e_done, vecs[i].e_err, vecs[i].e_lw,
                     vecs[i].e_cyc);
         end
      end
      @(negedge clk);
      clear_inputs();

      // Ten-word program load
      load(10, 1'b1, 32'h0010_0093);
      check("load10_words", 64'(loaded_words), 64'd10);
      check("load10_state", {62'd0, busy, err}, 64'd0);

      // Word and start in the same IDLE cycle: load wins, start dropped
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_data = 32'hCAFE_0001; bus.host_last = 1'b1;
      start = 1'b1; cycle_budget = 16'd5;
      #1;
      check("collide_write", {57'd0, imem_we, imem_addr}, {57'd0, 1'b1, 6'd0});
      @(negedge clk);
      clear_inputs();
      #1;
      check("collide_busy", 64'(busy), 64'd0);
      check("collide_lw", 64'(loaded_words), 64'd1);

      // Budget 30
      run_measure(16'd30, h, r, d, to);
      check("b30_timeout", 64'(to), 64'd0);
      check("b30_hold", 64'(h), 64'd2);
      check("b30_run", 64'(r), 64'd30);
      check("b30_done", 64'(d), 64'd1);
      check("b30_cycles", 64'(cycles), 64'd30);

      // Budget 0: straight from HOLD to DONE
      run_measure(16'd0, h, r, d, to);
      check("b0_timeout", 64'(to), 64'd0);
      check("b0_hold", 64'(h), 64'd2);
      check("b0_run", 64'(r), 64'd0);
      check("b0_done", 64'(d), 64'd1);
      check("b0_cycles", 64'(cycles), 64'd0);

`ifdef RUN_CTRL_HALT_EN
      @(negedge clk);
      start = 1'b1; cycle_budget = 16'd100;
      @(negedge clk);
      start = 1'b0;
      wait_run_cycles(16'd7, found);
      check("halt_reach7", 64'(found), 64'd1);
      core_halt = 1'b1;
      @(negedge clk);
      core_halt = 1'b0;
      #1;
      check("halt_done", {62'd0, done, core_rst}, {62'd0, 1'b1, 1'b1});
      check("halt_cycles", 64'(cycles), 64'd7);
      @(negedge clk);
      #1;
      check("halt_idle", 64'(busy), 64'd0);
`endif

      // Reset in the middle of a run
      @(negedge clk);
      start = 1'b1; cycle_budget = 16'd50;
      @(negedge clk);
      start = 1'b0;
      wait_run_cycles(16'd5, found);
      check("rst_reach5", 64'(found), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_abort", {38'd0, core_rst, busy, done, err, imem_we, 1'b0, loaded_words, cycles},
            {38'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0});
      seen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      check("rst_no_done", 64'(seen), 64'd0);

      // Overflow: 64 words, no last
      load(2, 1'b1, 32'h1234_0000);
      check("pre_ovf_lw", 64'(loaded_words), 64'd2);
      load(64, 1'b0, 32'h0BAD_0000);
      check("ovf_err", 64'(err), 64'd1);
      check("ovf_lw", 64'(loaded_words), 64'd0);
      check("ovf_idle", {62'd0, busy, bus.host_ready}, {62'd0, 1'b0, 1'b1});
      @(negedge clk);
      start = 1'b1; cycle_budget = 16'd5;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         #1;
         if (busy) seen = 1'b1;
         @(negedge clk);
      end
      check("ovf_start_ignored", 64'(seen), 64'd0);

      // A new load clears the sticky error
      load(1, 1'b1, 32'h0000_0013);
      check("reload_err", 64'(err), 64'd0);
      check("reload_lw", 64'(loaded_words), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
